// File: rtl/convex_pt_host_if.sv
// Point/drop/loader signal bundle for convex_pt_host, named from the host block's view.
// Log signals exist only when CONVEX_DROP_LOG_EN is defined.
interface convex_pt_host_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          i_clr;
    logic          i_ld_en;
    logic [9:0]    i_ld_x;
    logic [9:0]    i_ld_y;
    logic          i_start;
    logic          i_read_pt;
    logic [4:0]    o_pt_xy;
    logic [9:0]    i_drop_x;
    logic [9:0]    i_drop_y;
    logic          i_drop_v;
    logic [CW-1:0] o_pt_cnt;
    logic [7:0]    o_drop_cnt;
    logic          o_busy;
    logic          o_done;
    logic          o_underrun;
`ifdef CONVEX_DROP_LOG_EN
    logic          i_log_rd;
    logic [9:0]    o_log_x;
    logic [9:0]    o_log_y;
    logic          o_log_empty;
    logic          o_log_full;
    logic          o_log_ovf;
`endif

    modport slave (
`ifdef CONVEX_DROP_LOG_EN
        input  i_log_rd,
        output o_log_x, o_log_y, o_log_empty, o_log_full, o_log_ovf,
`endif
        input  i_clr, i_ld_en, i_ld_x, i_ld_y, i_start, i_read_pt,
        input  i_drop_x, i_drop_y, i_drop_v,
        output o_pt_xy, o_pt_cnt, o_drop_cnt, o_busy, o_done, o_underrun
    );

    modport master (
`ifdef CONVEX_DROP_LOG_EN
        output i_log_rd,
        input  o_log_x, o_log_y, o_log_empty, o_log_full, o_log_ovf,
`endif
        output i_clr, i_ld_en, i_ld_x, i_ld_y, i_start, i_read_pt,
        output i_drop_x, i_drop_y, i_drop_v,
        input  o_pt_xy, o_pt_cnt, o_drop_cnt, o_busy, o_done, o_underrun
    );
endinterface

// File: rtl/convex_pt_host.sv
// Host driver for the convex-hull engine: buffers points, serialises them as 5-bit chunks
// on READ_PT, counts drops. Optional drop-log FIFO enabled by defining CONVEX_DROP_LOG_EN.
module convex_pt_host #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOG_DEPTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    convex_pt_host_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t        r_state;
    logic [19:0]   r_mem [DEPTH];
    logic [CW-1:0] r_pt_cnt;
    logic [CW-1:0] r_rd_idx;
    logic [1:0]    r_ch;
    logic [4:0]    r_pt_xy;
    logic [7:0]    r_drop_cnt;
    logic          r_underrun;

    logic          w_load;
    logic          w_drop;
    logic [19:0]   w_cur;
    logic [4:0]    w_chunk;

    assign w_load = (r_state == ST_IDLE) && bus.i_ld_en && (r_pt_cnt != CW'(DEPTH));
    assign w_drop = (r_state != ST_IDLE) && bus.i_drop_v;
    assign w_cur  = r_mem[r_rd_idx[AW-1:0]];

    // Chunk order within a point: x high, x low, y high, y low
    always_comb begin
        w_chunk = w_cur[19:15];
        case (r_ch)
            2'd1:    w_chunk = w_cur[14:10];
            2'd2:    w_chunk = w_cur[9:5];
            2'd3:    w_chunk = w_cur[4:0];
            default: w_chunk = w_cur[19:15];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_load && !bus.i_clr) begin
            r_mem[r_pt_cnt[AW-1:0]] <= {bus.i_ld_x, bus.i_ld_y};
        end
    end

    // Control FSM; CLR overrides everything
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_pt_cnt   <= '0;
            r_rd_idx   <= '0;
            r_ch       <= '0;
            r_pt_xy    <= '0;
            r_drop_cnt <= '0;
            r_underrun <= 1'b0;
        end else if (bus.i_clr) begin
            r_state    <= ST_IDLE;
            r_pt_cnt   <= '0;
            r_rd_idx   <= '0;
            r_ch       <= '0;
            r_pt_xy    <= '0;
            r_drop_cnt <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) r_pt_cnt <= r_pt_cnt + CW'(1);
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_read_pt) begin
                        r_underrun <= 1'b1;
                        r_pt_xy    <= '0;
                    end
                    // START sees the pre-load count when LD_EN coincides
                    if (bus.i_start) r_state <= (r_pt_cnt != '0) ? ST_STREAM : ST_FINISH;
                end
                ST_STREAM: begin
                    if (bus.i_read_pt) begin
                        if ((r_rd_idx == r_pt_cnt) && (r_ch == 2'd0)) begin
                            r_state <= ST_FINISH;
                            r_pt_xy <= '0;
                        end else begin
                            r_pt_xy <= w_chunk;
                            r_ch    <= r_ch + 2'd1;
                            if (r_ch == 2'd3) r_rd_idx <= r_rd_idx + CW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    if (bus.i_read_pt) r_pt_xy <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_pt_xy    = r_pt_xy;
    assign bus.o_pt_cnt   = r_pt_cnt;
    assign bus.o_drop_cnt = r_drop_cnt;
    assign bus.o_busy     = (r_state == ST_STREAM);
    assign bus.o_done     = (r_state == ST_FINISH);
    assign bus.o_underrun = r_underrun;

`ifdef CONVEX_DROP_LOG_EN
    localparam int unsigned LAW = $clog2(LOG_DEPTH);

    logic [19:0]  r_log_mem [LOG_DEPTH];
    logic [LAW:0] r_wr_ptr;
    logic [LAW:0] r_rd_ptr;
    logic         r_log_ovf;
    logic         w_log_empty;
    logic         w_log_full;
    logic         w_pop;
    logic         w_push;

    assign w_log_empty = (r_wr_ptr == r_rd_ptr);
    assign w_log_full  = (r_wr_ptr[LAW] != r_rd_ptr[LAW]) &&
                         (r_wr_ptr[LAW-1:0] == r_rd_ptr[LAW-1:0]);
    assign w_pop       = bus.i_log_rd && !w_log_empty;
    // A simultaneous pop frees the slot, so a push into a full log still lands
    assign w_push      = w_drop && (!w_log_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(LOG_DEPTH); i++) r_log_mem[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_log_ovf <= 1'b0;
        end else if (bus.i_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_log_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_log_mem[r_wr_ptr[LAW-1:0]] <= {bus.i_drop_x, bus.i_drop_y};
                r_wr_ptr <= r_wr_ptr + (LAW+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (LAW+1)'(1);
            if (w_drop && !w_push) r_log_ovf <= 1'b1;
        end
    end

    assign bus.o_log_x     = r_log_mem[r_rd_ptr[LAW-1:0]][19:10];
    assign bus.o_log_y     = r_log_mem[r_rd_ptr[LAW-1:0]][9:0];
    assign bus.o_log_empty = w_log_empty;
    assign bus.o_log_full  = w_log_full;
    assign bus.o_log_ovf   = r_log_ovf;
`else
    logic w_unused_drop;
    assign w_unused_drop = ^{bus.i_drop_x, bus.i_drop_y};
`endif
endmodule

// File: tb/tb_convex_pt_host.sv
// Self-checking bench for convex_pt_host: vector table for control behaviour,
// scoreboard-checked chunk streams, and hand sequences for the corner cases.
module tb_convex_pt_host;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    convex_pt_host_if #(.DEPTH(DEPTH)) bus ();

    convex_pt_host #(.DEPTH(DEPTH), .LOG_DEPTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          clr, ld_en, start, rd, dv;
        logic [9:0]    x, y;
        logic [4:0]    e_xy;
        logic [CW-1:0] e_cnt;
        logic [7:0]    e_dcnt;
        logic          e_busy, e_done;
    } vec_t;

    vec_t        vecs [15];
    logic [19:0] m_pts [$];
    logic [4:0]  exp_q [$];
    int          m_idx;
    int          m_ch;
    logic [4:0]  m_last;
    logic        m_done;

    function automatic vec_t mk(input logic clr, ld, st, rd, dv, input logic [9:0] x, y,
                                input logic [4:0] exy, input int cnt, input int dcnt,
                                input logic busy, done);
        vec_t v;
        v.clr = clr; v.ld_en = ld; v.start = st; v.rd = rd; v.dv = dv;
        v.x = x; v.y = y; v.e_xy = exy; v.e_cnt = CW'(cnt); v.e_dcnt = 8'(dcnt);
        v.e_busy = busy; v.e_done = done;
        return v;
    endfunction

    function automatic logic [4:0] chunk_of(input logic [19:0] p, input int c);
        return 5'((p >> (15 - 5 * c)) & 20'h1F);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pts.delete();
        exp_q.delete();
        m_idx = 0; m_ch = 0; m_last = '0; m_done = 1'b0;
    endtask

    task automatic do_clr();
        bus.i_clr = 1'b1;
        step();
        bus.i_clr = 1'b0;
        model_reset();
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y);
        bus.i_ld_en = 1'b1; bus.i_ld_x = x; bus.i_ld_y = y;
        step();
        bus.i_ld_en = 1'b0;
        if (m_pts.size() < DEPTH) m_pts.push_back({x, y});
    endtask

    task automatic do_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    // One streaming cycle: expected chunk pushed at drive, popped after the edge
    task automatic cyc(input logic rd);
        logic [4:0] e;
        bus.i_read_pt = rd;
        e = m_last;
        if (rd) begin
            if (m_done || (m_idx == m_pts.size() && m_ch == 0)) begin
                e = '0;
                m_done = 1'b1;
            end else begin
                e = chunk_of(m_pts[m_idx], m_ch);
                m_ch++;
                if (m_ch == 4) begin m_ch = 0; m_idx++; end
            end
        end
        m_last = e;
        exp_q.push_back(e);
        step();
        bus.i_read_pt = 1'b0;
        chk($sformatf("stream pt_xy idx%0d", m_idx), 32'(bus.o_pt_xy), 32'(exp_q.pop_front()));
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        bus.i_clr = 0; bus.i_ld_en = 0; bus.i_ld_x = 0; bus.i_ld_y = 0;
        bus.i_start = 0; bus.i_read_pt = 0;
        bus.i_drop_x = 0; bus.i_drop_y = 0; bus.i_drop_v = 0;
`ifdef CONVEX_DROP_LOG_EN
        bus.i_log_rd = 0;
`endif
        model_reset();

        //            clr ld st rd dv  x       y       xy     cnt dcnt busy done
        vecs[0]  = mk(1, 0, 0, 0, 0, 10'h000, 10'h000, 5'h00, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 10'h3A5, 10'h01F, 5'h00, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 10'h000, 10'h000, 5'h00, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 10'h000, 10'h000, 5'h00, 1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h000, 5'h1D, 1, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h000, 5'h05, 1, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h000, 5'h00, 1, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 1, 1, 10'h000, 10'h000, 5'h1F, 1, 1, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 10'h000, 10'h000, 5'h1F, 1, 1, 1, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 10'h000, 10'h000, 5'h00, 1, 1, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 1, 10'h000, 10'h000, 5'h00, 1, 2, 0, 1);
        vecs[11] = mk(0, 1, 0, 0, 0, 10'h111, 10'h222, 5'h00, 1, 2, 0, 1);
        vecs[12] = mk(1, 0, 0, 0, 0, 10'h000, 10'h000, 5'h00, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 0, 10'h155, 10'h2AA, 5'h00, 1, 0, 0, 1);
        vecs[14] = mk(1, 0, 0, 0, 0, 10'h000, 10'h000, 5'h00, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("reset pt_xy", 32'(bus.o_pt_xy), 32'h0);
        chk("reset pt_cnt", 32'(bus.o_pt_cnt), 32'h0);
        chk("reset drop_cnt", 32'(bus.o_drop_cnt), 32'h0);
        chk("reset busy", 32'(bus.o_busy), 32'h0);
        chk("reset done", 32'(bus.o_done), 32'h0);
        chk("reset underrun", 32'(bus.o_underrun), 32'h0);
`ifdef CONVEX_DROP_LOG_EN
        chk("reset log_empty", 32'(bus.o_log_empty), 32'h1);
`endif

        for (int i = 0; i < 15; i++) begin
            bus.i_clr = vecs[i].clr; bus.i_ld_en = vecs[i].ld_en; bus.i_start = vecs[i].start;
            bus.i_read_pt = vecs[i].rd; bus.i_drop_v = vecs[i].dv;
            bus.i_ld_x = vecs[i].x; bus.i_ld_y = vecs[i].y;
            step();
            chk($sformatf("vec%0d pt_xy", i), 32'(bus.o_pt_xy), 32'(vecs[i].e_xy));
            chk($sformatf("vec%0d pt_cnt", i), 32'(bus.o_pt_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d drop_cnt", i), 32'(bus.o_drop_cnt), 32'(vecs[i].e_dcnt));
            chk($sformatf("vec%0d busy", i), 32'(bus.o_busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(bus.o_done), 32'(vecs[i].e_done));
        end
        bus.i_clr = 0; bus.i_ld_en = 0; bus.i_start = 0; bus.i_read_pt = 0; bus.i_drop_v = 0;
        model_reset();

        // Three points, 12 back-to-back chunks, then one more request ends the stream
        for (int i = 0; i < 3; i++) load(10'($urandom), 10'($urandom));
        do_start();
        for (int i = 0; i < 13; i++) cyc(1'b1);
        chk("3pt done", 32'(bus.o_done), 32'h1);
        chk("3pt busy", 32'(bus.o_busy), 32'h0);

        // Stalled requests: 2 high / 5 low, chunks must neither repeat nor skip
        do_clr();
        load(10'h2C7, 10'h13B);
        load(10'h0F0, 10'h3E1);
        do_start();
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1); cyc(1'b1);
            for (int k = 0; k < 5; k++) cyc(1'b0);
        end
        chk("stall busy", 32'(bus.o_busy), 32'h1);
        cyc(1'b1);
        chk("stall done", 32'(bus.o_done), 32'h1);

        // START with an empty list
        do_clr();
        do_start();
        chk("empty start done", 32'(bus.o_done), 32'h1);
        chk("empty start busy", 32'(bus.o_busy), 32'h0);

        // READ_PT before START
        do_clr();
        bus.i_read_pt = 1'b1;
        step();
        bus.i_read_pt = 1'b0;
        chk("underrun", 32'(bus.o_underrun), 32'h1);
        chk("underrun pt_xy", 32'(bus.o_pt_xy), 32'h0);

        // Overfill the list; extras must neither count nor be streamed
        do_clr();
        for (int i = 0; i < int'(DEPTH) + 2; i++) load(10'(i * 37 + 5), 10'(1000 - i * 11));
        chk("full pt_cnt", 32'(bus.o_pt_cnt), 32'(DEPTH));
        do_start();
        for (int i = 0; i < int'(DEPTH) * 4 + 1; i++) cyc(1'b1);
        chk("full done", 32'(bus.o_done), 32'h1);

        // Drop counter saturation (counted in FINISH)
        bus.i_drop_v = 1'b1;
        repeat (100) step();
        chk("drop_cnt 100", 32'(bus.o_drop_cnt), 32'd100);
        repeat (200) step();
        bus.i_drop_v = 1'b0;
        chk("drop_cnt sat", 32'(bus.o_drop_cnt), 32'd255);
        step();
        chk("drop_cnt hold", 32'(bus.o_drop_cnt), 32'd255);

`ifdef CONVEX_DROP_LOG_EN
        do_clr();
        chk("log empty after clr", 32'(bus.o_log_empty), 32'h1);
        chk("log ovf after clr", 32'(bus.o_log_ovf), 32'h0);
        load(10'h001, 10'h002);
        do_start();
        for (int i = 0; i < 17; i++) begin
            bus.i_drop_v = 1'b1; bus.i_drop_x = 10'(i + 1); bus.i_drop_y = 10'(10'h200 + i);
            step();
        end
        bus.i_drop_v = 1'b0;
        chk("log full", 32'(bus.o_log_full), 32'h1);
        chk("log ovf", 32'(bus.o_log_ovf), 32'h1);
        chk("log head x", 32'(bus.o_log_x), 32'd1);
        chk("log head y", 32'(bus.o_log_y), 32'h200);
        bus.i_log_rd = 1'b1;
        step();
        bus.i_log_rd = 1'b0;
        chk("log pop x", 32'(bus.o_log_x), 32'd2);
        chk("log pop full", 32'(bus.o_log_full), 32'h0);
        do_clr();
        chk("log clr empty", 32'(bus.o_log_empty), 32'h1);
        chk("log clr ovf", 32'(bus.o_log_ovf), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
